// File: rtl/btn_pkg.sv
// Shared types for the button front end: the per-channel FSM state encoding.
package btn_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE    = 2'd0,
        BTN_PRESSED = 2'd1,
        BTN_LONG    = 2'd2
    } btn_state_t;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, press/long/repeat FSM.
// Auto-repeat in LONG is built only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic       btn_long,
    output btn_state_t dbg_state
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("btn_channel: DEBOUNCE_CYCLES>=1, HOLD_CYCLES>=2, REPEAT_CYCLES>=1 required");
    end

    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_level;
    logic            w_diff;
    logic            w_accept;
    logic            w_rise;
    logic            w_fall;

    assign w_diff   = (r_sync2 != r_level);
    // The cycle that would bring the count to DEBOUNCE_CYCLES is the accept cycle.
    assign w_accept = w_diff && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign w_rise   = w_accept && !r_level;
    assign w_fall   = w_accept && r_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            if (!w_diff) begin
                r_db_cnt <= '0;
            end else if (w_accept) begin
                r_db_cnt <= '0;
                r_level  <= ~r_level;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    btn_state_t        r_state;
    btn_state_t        w_state_nx;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nx;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic              w_press_nx;
    logic              w_release_nx;
    logic              w_long_nx;

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] w_rep_nx;
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_hold_nx    = r_hold_cnt;
        w_press_nx   = 1'b0;
        w_release_nx = 1'b0;
        w_long_nx    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        w_rep_nx     = r_rep_cnt;
`endif
        case (r_state)
            BTN_IDLE: begin
                if (w_rise) begin
                    w_state_nx = BTN_PRESSED;
                    w_press_nx = 1'b1;
                    w_hold_nx  = '0;
                end
            end
            BTN_PRESSED: begin
                // A fall on the threshold cycle wins: release only, no long pulse.
                if (w_fall) begin
                    w_state_nx   = BTN_IDLE;
                    w_release_nx = 1'b1;
                    w_hold_nx    = '0;
`ifdef BTN_AUTOREPEAT_EN
                    w_rep_nx     = '0;
`endif
                end else if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    w_state_nx = BTN_LONG;
                    w_long_nx  = 1'b1;
                    w_hold_nx  = HOLD_W'(HOLD_CYCLES);
`ifdef BTN_AUTOREPEAT_EN
                    w_rep_nx   = '0;
`endif
                end else begin
                    w_hold_nx = r_hold_cnt + 1'b1;
                end
            end
            BTN_LONG: begin
                if (w_fall) begin
                    w_state_nx   = BTN_IDLE;
                    w_release_nx = 1'b1;
                    w_hold_nx    = '0;
`ifdef BTN_AUTOREPEAT_EN
                    w_rep_nx     = '0;
                end else if (r_rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
                    w_rep_nx   = '0;
                    w_press_nx = 1'b1;
                end else begin
                    w_rep_nx = r_rep_cnt + 1'b1;
`endif
                end
            end
            default: begin
                w_state_nx = BTN_IDLE;
                w_hold_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= BTN_IDLE;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            r_rep_cnt  <= '0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_hold_cnt <= w_hold_nx;
            r_press    <= w_press_nx;
            r_release  <= w_release_nx;
            r_long     <= w_long_nx;
`ifdef BTN_AUTOREPEAT_EN
            r_rep_cnt  <= w_rep_nx;
`endif
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign btn_long    = r_long;
    assign dbg_state   = r_state;

endmodule

// File: rtl/button_pulse_array.sv
// N_BTN independent debounced button channels with press/release/long pulses.
// Define BTN_AUTOREPEAT_EN to get periodic press pulses while held past the long threshold.
module button_pulse_array
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 250
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_BTN-1:0]   btn,
    output logic [N_BTN-1:0]   btn_level,
    output logic [N_BTN-1:0]   btn_press,
    output logic [N_BTN-1:0]   btn_release,
    output logic [N_BTN-1:0]   btn_long,
    output logic [2*N_BTN-1:0] dbg_state
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_state_t w_state;

        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn         (btn[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_long    (btn_long[i]),
            .dbg_state   (w_state)
        );

        assign dbg_state[2*i +: 2] = w_state;
    end

endmodule

// File: tb/tb_button_pulse_array.sv
// Directed bench for button_pulse_array with DEBOUNCE=4, HOLD=20, REPEAT=8.
module tb_button_pulse_array;

    localparam int N_BTN = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_BTN-1:0]   btn;
    logic [N_BTN-1:0]   btn_level;
    logic [N_BTN-1:0]   btn_press;
    logic [N_BTN-1:0]   btn_release;
    logic [N_BTN-1:0]   btn_long;
    logic [2*N_BTN-1:0] dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    button_pulse_array #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] cur();
        return {btn_level, btn_press, btn_release, btn_long};
    endfunction

    function automatic logic [15:0] pk(input logic [3:0] l, input logic [3:0] p,
                                       input logic [3:0] r, input logic [3:0] g);
        return {l, p, r, g};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        // Reset: everything quiet and all FSMs idle.
        rst_n = 1'b0;
        btn   = '0;
        repeat (3) step();
        chk("reset_out", cur(), 16'h0000);
        chk("reset_state", {8'h00, dbg_state}, 16'h0000);
        rst_n = 1'b1;
        step();
        chk("post_reset_out", cur(), 16'h0000);

        // Clean press on ch0 for 10 cycles, then release.
        btn[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("s1_press k=%0d", k), cur(),
                pk({3'b0, k >= 6}, {3'b0, k == 6}, 4'h0, 4'h0));
        end
        btn[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("s1_release k=%0d", k), cur(),
                pk({3'b0, k < 6}, 4'h0, {3'b0, k == 6}, 4'h0));
        end

        // 3-cycle glitch on ch1: one short of the debounce length.
        btn[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) btn[1] = 1'b0;
            step();
            chk($sformatf("s2_glitch k=%0d", k), cur(), 16'h0000);
        end

        // Long hold on ch2: press 6, long 26, repeats 34/42/50/58 when enabled.
        btn[2] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            chk($sformatf("s3_hold k=%0d", k), cur(),
                pk({1'b0, k >= 6, 2'b0},
                   {1'b0, (k == 6) || (REP_EN && (k == 34 || k == 42 || k == 50 || k == 58)), 2'b0},
                   4'h0,
                   {1'b0, k == 26, 2'b0}));
        end
        chk("s3_state_long", {14'h0, dbg_state[5:4]}, 16'd2);
        // Release lands on edge 66, which is also a repeat wrap: release only.
        btn[2] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("s3_release k=%0d", k), cur(),
                pk({1'b0, k < 6, 2'b0}, 4'h0, {1'b0, k == 6, 2'b0}, 4'h0));
        end

        // Ch3 release accepted on the exact long-threshold edge (26).
        btn[3] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            if (k == 21) btn[3] = 1'b0;
            step();
            chk($sformatf("s4_threshold k=%0d", k), cur(),
                pk({k >= 6 && k <= 25, 3'b0}, {k == 6, 3'b0}, {k == 26, 3'b0}, 4'h0));
        end
        chk("s4_state_idle", {8'h00, dbg_state}, 16'h0000);

        // Ch0 and ch3 together.
        btn = 4'b1001;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("s5_press k=%0d", k), cur(),
                pk({k >= 6, 2'b0, k >= 6}, {k == 6, 2'b0, k == 6}, 4'h0, 4'h0));
        end
        btn = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("s5_release k=%0d", k), cur(),
                pk({k < 6, 2'b0, k < 6}, 4'h0, {k == 6, 2'b0, k == 6}, 4'h0));
        end

        // Reset mid-hold on ch0: no release, fresh press after reset.
        btn[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("s6_hold k=%0d", k), cur(),
                pk({3'b0, k >= 6}, {3'b0, k == 6}, 4'h0, 4'h0));
        end
        rst_n = 1'b0;
        step();
        chk("s6_in_reset", cur(), 16'h0000);
        chk("s6_in_reset_state", {8'h00, dbg_state}, 16'h0000);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("s6_repress k=%0d", k), cur(),
                pk({3'b0, k >= 6}, {3'b0, k == 6}, 4'h0, 4'h0));
        end
        btn[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("s6_release k=%0d", k), cur(),
                pk({3'b0, k < 6}, 4'h0, {3'b0, k == 6}, 4'h0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
